// File: rtl/dct_serial_pkg.sv
// Shared types and frame-length constants for the serial host.
// DCT_HOST_PARITY_EN adds one even-parity bit to every frame.
package dct_serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } tx_state_e;

`ifdef DCT_HOST_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int frame_len(input int data_w);
    return data_w + PAR_BITS;
  endfunction

endpackage

// File: rtl/dct_serial_rx.sv
// Serial-to-parallel receiver with length (and optional parity) check.
// DCT_HOST_PARITY_EN: expects a trailing even-parity bit.
module dct_serial_rx
  import dct_serial_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iSVAL,
  input  logic              iSDAT,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oFrameErr
);

  localparam int FRAME_W = frame_len(DATA_W);
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_W + 1);

  logic [FRAME_W-1:0] r_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_prev;
  logic               r_valid;
  logic               r_err;
  logic [DATA_W-1:0]  r_data;
  logic               w_par_ok;

`ifdef DCT_HOST_PARITY_EN
  assign w_par_ok = ~(^r_sh);
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_prev  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_prev  <= iSVAL;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (iSVAL) begin
        r_sh <= {r_sh[FRAME_W-2:0], iSDAT};
        if (r_cnt != CNT_SAT)
          r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_prev) begin
        // Frame just closed: judge it and rearm.
        r_cnt <= '0;
        if (r_cnt == CNT_FULL && w_par_ok) begin
          r_valid <= 1'b1;
          r_data  <= r_sh[FRAME_W-1 -: DATA_W];
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign oValid    = r_valid;
  assign oData     = r_data;
  assign oFrameErr = r_err;

endmodule

// File: rtl/dct_serial_host.sv
// Serial host: parallel-to-serial TX FSM plus dct_serial_rx.
// DCT_HOST_PARITY_EN: TX appends an even-parity bit.
module dct_serial_host
  import dct_serial_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int GAP_MIN = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iData,
  output logic              oSVAL,
  output logic              oSDAT,
  input  logic              iSVAL,
  input  logic              iSDAT,
  output logic              oValid,
  output logic [DATA_W-1:0] oData,
  output logic              oFrameErr
);

  localparam int FRAME_W = frame_len(DATA_W);
  localparam int BCNT_W = $clog2(FRAME_W + 1);

  tx_state_e           r_state;
  logic [FRAME_W-1:0]  r_sh;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [3:0]          r_gcnt;
  logic                r_ready;
  logic                r_sval;
  logic                r_sdat;
  logic [FRAME_W-1:0]  w_word;
  logic                w_accept;

`ifdef DCT_HOST_PARITY_EN
  assign w_word = {iData, ^iData};
`else
  assign w_word = iData;
`endif

  assign w_accept = iValid & r_ready;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_bcnt  <= '0;
      r_gcnt  <= '0;
      r_ready <= 1'b0;
      r_sval  <= 1'b0;
      r_sdat  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_state <= S_SHIFT;
            r_ready <= 1'b0;
            r_sval  <= 1'b1;
            r_sdat  <= w_word[FRAME_W-1];
            r_sh    <= {w_word[FRAME_W-2:0], 1'b0};
            r_bcnt  <= BCNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (r_bcnt == BCNT_W'(FRAME_W)) begin
            r_state <= S_GAP;
            r_sval  <= 1'b0;
            r_sdat  <= 1'b0;
            r_gcnt  <= 4'd1;
          end else begin
            r_sdat <= r_sh[FRAME_W-1];
            r_sh   <= {r_sh[FRAME_W-2:0], 1'b0};
            r_bcnt <= r_bcnt + BCNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_gcnt == 4'(GAP_MIN)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_gcnt <= r_gcnt + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign oReady = r_ready;
  assign oSVAL  = r_sval;
  assign oSDAT  = r_sdat;

  dct_serial_rx #(
    .DATA_W(DATA_W)
  ) u_rx (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iSVAL    (iSVAL),
    .iSDAT    (iSDAT),
    .oValid   (oValid),
    .oData    (oData),
    .oFrameErr(oFrameErr)
  );

endmodule

// File: tb/tb_dct_serial_host.sv
// Directed bench for dct_serial_host (default and parity builds).
module tb_dct_serial_host;

`ifdef DCT_HOST_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FW = 16 + PB;

  logic        iClk;
  logic        iRst_n;
  logic        iValid;
  logic        oReady;
  logic [15:0] iData;
  logic        oSVAL;
  logic        oSDAT;
  logic        iSVAL;
  logic        iSDAT;
  logic        oValid;
  logic [15:0] oData;
  logic        oFrameErr;

  logic loop;
  logic tb_sval;
  logic tb_sdat;
  int   n_cmp;
  int   n_fail;
  int   fr_v;
  int   fr_e;

  assign iSVAL = loop ? oSVAL : tb_sval;
  assign iSDAT = loop ? oSDAT : tb_sdat;

  dct_serial_host #(
    .DATA_W (16),
    .GAP_MIN(1)
  ) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iValid   (iValid),
    .oReady   (oReady),
    .iData    (iData),
    .oSVAL    (oSVAL),
    .oSDAT    (oSDAT),
    .iSVAL    (iSVAL),
    .iSDAT    (iSDAT),
    .oValid   (oValid),
    .oData    (oData),
    .oFrameErr(oFrameErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic rx_frame(input int n, input logic [31:0] bits);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge iClk);
      if (oValid) fr_v++;
      if (oFrameErr) fr_e++;
      tb_sval = 1'b1;
      tb_sdat = bits[i];
    end
    @(negedge iClk);
    if (oValid) fr_v++;
    if (oFrameErr) fr_e++;
    tb_sval = 1'b0;
    tb_sdat = 1'b0;
    repeat (3) begin
      @(negedge iClk);
      if (oValid) fr_v++;
      if (oFrameErr) fr_e++;
    end
  endtask

  task automatic test_reset;
    iRst_n = 1'b0; iValid = 1'b0; iData = '0;
    tb_sval = 1'b0; tb_sdat = 1'b0; loop = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    n_cmp++;
    if (oReady !== 1'b0) begin
      n_fail++; $display("FAIL rst_ready: got %b want 0", oReady);
    end
    n_cmp++;
    if (oSVAL !== 1'b0 || oSDAT !== 1'b0) begin
      n_fail++; $display("FAIL rst_serial: got %b%b want 00", oSVAL, oSDAT);
    end
    n_cmp++;
    if (oValid !== 1'b0 || oFrameErr !== 1'b0) begin
      n_fail++; $display("FAIL rst_pulses: got %b%b want 00", oValid, oFrameErr);
    end
    n_cmp++;
    if (oData !== 16'h0000) begin
      n_fail++; $display("FAIL rst_data: got %h want 0000", oData);
    end
    iRst_n = 1'b1;
    @(negedge iClk);
    n_cmp++;
    if (oReady !== 1'b1) begin
      n_fail++; $display("FAIL rst_release_ready: got %b want 1", oReady);
    end
  endtask

  task automatic test_single;
    logic [15:0] cap;
    int hi_bad;
    int rdy_bad;
    cap = '0; hi_bad = 0; rdy_bad = 0;
    @(negedge iClk);
    iValid = 1'b1; iData = 16'hA5C3;
    @(posedge iClk);
    #1 iValid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge iClk);
      cap = {cap[14:0], oSDAT};
      if (oSVAL !== 1'b1) hi_bad++;
      if (oReady !== 1'b0) rdy_bad++;
    end
    repeat (PB) @(negedge iClk);
    n_cmp++;
    if (cap !== 16'b1010010111000011) begin
      n_fail++; $display("FAIL single_bits: got %b want 1010010111000011", cap);
    end
    n_cmp++;
    if (hi_bad != 0 || rdy_bad != 0) begin
      n_fail++; $display("FAIL single_strobe: sval_low=%0d ready_hi=%0d want 0/0", hi_bad, rdy_bad);
    end
    @(negedge iClk);
    n_cmp++;
    if (oSVAL !== 1'b0 || oSDAT !== 1'b0 || oReady !== 1'b0) begin
      n_fail++; $display("FAIL single_gap: got sval=%b sdat=%b rdy=%b want 000", oSVAL, oSDAT, oReady);
    end
    @(negedge iClk);
    n_cmp++;
    if (oReady !== 1'b1) begin
      n_fail++; $display("FAIL single_ready_t18: got %b want 1", oReady);
    end
  endtask

  task automatic test_back_to_back;
    int acc [2];
    int n_acc;
    int busy_hi;
    n_acc = 0; busy_hi = 0; acc[0] = 0; acc[1] = 0;
    @(negedge iClk);
    iValid = 1'b1; iData = 16'h0001;
    for (int c = 0; c < 80 && n_acc < 2; c++) begin
      if (c > 0) @(negedge iClk);
      if (n_acc == 1) iData = 16'h8000;
      if (oReady) begin
        acc[n_acc] = c;
        n_acc++;
      end else if (n_acc == 0) begin
        busy_hi = busy_hi + 0;
      end
    end
    @(posedge iClk);
    #1 iValid = 1'b0;
    n_cmp++;
    if (n_acc != 2 || acc[1] - acc[0] != 18 + PB) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d accepts gap %0d want 2 gap %0d", n_acc, acc[1] - acc[0], 18 + PB);
    end
    @(negedge iClk);
    n_cmp++;
    if (oSVAL !== 1'b1 || oSDAT !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_msb: got %b%b want 11", oSVAL, oSDAT);
    end
    for (int c = 0; c < 17 + PB; c++) begin
      @(negedge iClk);
      if (oReady) busy_hi++;
    end
    n_cmp++;
    if (busy_hi != 1) begin
      n_fail++; $display("FAIL b2b_ready_busy: got %0d ready cycles want 1", busy_hi);
    end
    repeat (4) @(negedge iClk);
  endtask

  task automatic test_loopback;
    logic [15:0] w [100];
    int tx_i;
    int rx_i;
    int ferr;
    int nv;
    tx_i = 0; rx_i = 0; ferr = 0; nv = 0;
    for (int i = 0; i < 100; i++) w[i] = 16'($urandom);
    w[0] = 16'h0000;
    w[1] = 16'hFFFF;
    loop = 1'b1;
    for (int c = 0; c < 3000 && nv < 100; c++) begin
      @(negedge iClk);
      if (oFrameErr) ferr++;
      if (oValid) begin
        if (rx_i < 100) begin
          n_cmp++;
          if (oData !== w[rx_i]) begin
            n_fail++; $display("FAIL loop_data[%0d]: got %h want %h", rx_i, oData, w[rx_i]);
          end
        end
        rx_i++;
        nv++;
      end
      if (tx_i < 100) begin
        iValid = 1'b1;
        iData = w[tx_i];
        if (oReady) tx_i++;
      end else begin
        iValid = 1'b0;
      end
    end
    iValid = 1'b0;
    repeat (25) begin
      @(negedge iClk);
      if (oFrameErr) ferr++;
      if (oValid) nv++;
    end
    n_cmp++;
    if (nv != 100) begin
      n_fail++; $display("FAIL loop_count: got %0d want 100", nv);
    end
    n_cmp++;
    if (ferr != 0) begin
      n_fail++; $display("FAIL loop_frame_err: got %0d want 0", ferr);
    end
    loop = 1'b0;
  endtask

  task automatic test_framing;
    logic [31:0] b;
    logic [15:0] g;
    fr_v = 0; fr_e = 0;
    b = 32'h5555_4321;
    rx_frame(FW - 1, b);
    n_cmp++;
    if (fr_e != 1 || fr_v != 0) begin
      n_fail++; $display("FAIL frame_short: got err=%0d val=%0d want 1/0", fr_e, fr_v);
    end
    rx_frame(FW + 1, b);
    n_cmp++;
    if (fr_e != 2 || fr_v != 0) begin
      n_fail++; $display("FAIL frame_long: got err=%0d val=%0d want 2/0", fr_e, fr_v);
    end
    g = 16'h1234;
    if (PB == 1) b = {15'd0, g, ^g};
    else b = {16'd0, g};
    rx_frame(FW, b);
    n_cmp++;
    if (fr_v != 1 || fr_e != 2) begin
      n_fail++; $display("FAIL frame_good_pulse: got val=%0d err=%0d want 1/2", fr_v, fr_e);
    end
    n_cmp++;
    if (oData !== 16'h1234) begin
      n_fail++; $display("FAIL frame_good_data: got %h want 1234", oData);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] cap;
    logic [31:0] exp_cap;
    int nv;
    int ne;
    logic [15:0] got;
    cap = '0; nv = 0; ne = 0; got = '0;
    loop = 1'b0;
    @(negedge iClk);
    iValid = 1'b1; iData = 16'hFFFF;
    tb_sval = 1'b1; tb_sdat = 1'b1;
    @(posedge iClk);
    #1 iValid = 1'b0;
    repeat (6) @(negedge iClk);
    n_cmp++;
    if (oSVAL !== 1'b1) begin
      n_fail++; $display("FAIL mid_inflight: got %b want 1", oSVAL);
    end
    iRst_n = 1'b0; tb_sval = 1'b0; tb_sdat = 1'b0;
    @(negedge iClk);
    n_cmp++;
    if (oSVAL !== 1'b0 || oSDAT !== 1'b0 || oReady !== 1'b0) begin
      n_fail++; $display("FAIL mid_abort: got sval=%b sdat=%b rdy=%b want 000", oSVAL, oSDAT, oReady);
    end
    iRst_n = 1'b1;
    repeat (6) begin
      @(negedge iClk);
      if (oValid) nv++;
      if (oFrameErr) ne++;
    end
    n_cmp++;
    if (nv != 0 || ne != 0) begin
      n_fail++; $display("FAIL mid_no_pulse: got val=%0d err=%0d want 0/0", nv, ne);
    end
    loop = 1'b1;
    iValid = 1'b1; iData = 16'h5A3C;
    @(posedge iClk);
    #1 iValid = 1'b0;
    for (int k = 0; k < FW; k++) begin
      @(negedge iClk);
      cap = {cap[30:0], oSDAT};
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge iClk);
      if (oValid) begin nv++; got = oData; end
      if (oFrameErr) ne++;
    end
    exp_cap = 32'h5A3C;
    if (PB == 1) exp_cap = {exp_cap[30:0], 1'b0};
    n_cmp++;
    if (cap !== exp_cap) begin
      n_fail++; $display("FAIL mid_next_bits: got %h want %h", cap, exp_cap);
    end
    n_cmp++;
    if (nv != 1 || ne != 0 || got !== 16'h5A3C) begin
      n_fail++; $display("FAIL mid_next_rx: got val=%0d err=%0d data=%h want 1/0/5a3c", nv, ne, got);
    end
    loop = 1'b0;
  endtask

`ifdef DCT_HOST_PARITY_EN
  task automatic test_parity;
    logic [16:0] cap;
    logic [31:0] b;
    int v0;
    int e0;
    cap = '0;
    @(negedge iClk);
    iValid = 1'b1; iData = 16'h0007;
    @(posedge iClk);
    #1 iValid = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge iClk);
      cap = {cap[15:0], oSDAT};
    end
    n_cmp++;
    if (cap !== 17'h0000F) begin
      n_fail++; $display("FAIL par_tx_bits: got %b want 00000000000001111", cap);
    end
    repeat (4) @(negedge iClk);
    v0 = fr_v; e0 = fr_e;
    b = {15'd0, 16'h1234, 1'b0};
    rx_frame(17, b);
    n_cmp++;
    if (fr_e != e0 + 1 || fr_v != v0) begin
      n_fail++; $display("FAIL par_rx_flip: got err+%0d val+%0d want 1/0", fr_e - e0, fr_v - v0);
    end
  endtask
`endif

  initial begin
    n_cmp = 0; n_fail = 0; fr_v = 0; fr_e = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_loopback();
    test_framing();
    test_reset_mid();
`ifdef DCT_HOST_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dct_serial_host.md
DCT_SERIAL_HOST -- requirements
Module: dct_serial_host

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bits per serial word.
REQ-002 SHALL have parameter GAP_MIN, default 1: minimum idle cycles (SVAL low) between transmitted words, range 1..15.
REQ-003 SHALL have a single clock, iClk; the reset, iRst_n, SHALL be synchronous and active-low.
REQ-004 Ports, as name  direction  width  meaning:
- iClk  in  1  clock
- iRst_n  in  1  synchronous active-low reset
- iValid  in  1  parallel TX word valid
- oReady  out  1  TX accepts word this cycle
- iData  in  DATA_W  parallel TX word
- oSVAL  out  1  serial TX frame strobe, drives core serial input
- oSDAT  out  1  serial TX data bit
- iSVAL  in  1  serial RX frame strobe, from core serial output
- iSDAT  in  1  serial RX data bit
- oValid  out  1  parallel RX word valid, one-cycle pulse
- oData  out  DATA_W  parallel RX word
- oFrameErr  out  1  RX framing error, one-cycle pulse

Function
REQ-005 Serial frame SHALL be SVAL high for exactly DATA_W consecutive cycles, SDAT MSB first, then SVAL low for at least one cycle (parity bit extends the frame, see REQ-016).
REQ-006 TX FSM states SHALL be IDLE, SHIFT and GAP; oReady SHALL equal 1 only in IDLE.
REQ-007 IDLE->SHIFT on iValid&&oReady; iData SHALL be captured in a shift register in that cycle.
REQ-008 The cycle after acceptance, oSVAL=1 and oSDAT=iData[DATA_W-1]; bit k SHALL appear DATA_W-k cycles after acceptance, so the LSB is on the wire at t+DATA_W.
REQ-009 SHIFT->GAP after the last bit; in GAP, oSVAL=0 and oSDAT=0 for exactly GAP_MIN cycles, then ->IDLE. Maximum throughput SHALL be one word per DATA_W+GAP_MIN+1 cycles.
REQ-010 oSDAT SHALL be 0 whenever oSVAL=0; oSVAL and oSDAT SHALL be registered outputs.
REQ-011 RX SHALL shift iSDAT in on every cycle with iSVAL=1 and count bits with a counter saturating at DATA_W+1.
REQ-012 On the cycle iSVAL is sampled low after being high: if count==DATA_W, then oValid=1 for one cycle on the next edge, with oData = assembled word; otherwise oFrameErr=1 for one cycle and the word SHALL be discarded.
REQ-013 Long frame (iSVAL high beyond DATA_W bits): oFrameErr SHALL pulse once at the falling edge of iSVAL; no oValid.
REQ-014 oData SHALL hold its last value between oValid pulses. RX has no backpressure, and TX and RX SHALL operate fully independently and concurrently.

Reset
REQ-015 While iRst_n=0 at an iClk edge: TX->IDLE, oSVAL=0, oSDAT=0, oReady=0 during reset and 1 the cycle after release; RX counter=0, oValid=0, oFrameErr=0, oData=0. A frame in flight SHALL be aborted, not resumed, and no error SHALL be reported for it.

Configuration
REQ-016 With DCT_HOST_PARITY_EN defined: TX SHALL append one even-parity bit (XOR of the word) as frame bit DATA_W+1; RX SHALL expect DATA_W+1 bits and, on a length match with a parity mismatch, SHALL pulse oFrameErr instead of oValid.
REQ-017 Without DCT_HOST_PARITY_EN: frames SHALL be exactly DATA_W bits, with no parity logic present.

Structure
REQ-018 The TX state typedef and frame-length constants SHALL live in shared package dct_serial_pkg.
REQ-019 RX SHALL be a sub-module dct_serial_rx; TX SHALL remain in the top level.

Verification
REQ-020 Single word: reset, then iData=16'hA5C3 with iValid=1 -> oSVAL high in cycles t+1..t+16 carrying 1010010111000011, then low for 1 cycle, oReady=1 again at t+18.
REQ-021 Back-to-back: iValid held high with 16'h0001 then 16'h8000 -> second acceptance exactly 18 cycles after the first; oReady=0 in between.
REQ-022 Loopback: oSVAL/oSDAT tied to iSVAL/iSDAT and 100 random words sent -> 100 oValid pulses, data matching in order, no oFrameErr.
REQ-023 Framing: RX driven with a 15-bit frame, then a 17-bit frame -> two oFrameErr pulses and no oValid; a following good 16'h1234 frame -> oValid with oData=16'h1234.
REQ-024 Reset mid-frame: iRst_n=0 at bit 7 of TX and RX -> oSVAL=0 next edge, no oValid or oFrameErr; the next word transmits correctly.
REQ-025 Parity build (DCT_HOST_PARITY_EN): 16'h0007 -> 17th bit = 1; RX frame with a flipped parity bit -> oFrameErr, no oValid.
